// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue scoreboard: operand field positions,
// register-file size and the output-stage state encoding.
package rv_issue_pkg;

  localparam int REG_NUM = 32;
  localparam int REG_W   = 5;
  localparam int RS2_LSB = 20;
  localparam int RS1_LSB = 15;
  localparam int RD_LSB  = 7;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
  } ops_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_STALL
  } iss_state_e;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Handshake bundle of the issue scoreboard: instruction input, issue output,
// writeback retire, flush and stall counter. slave = DUT side, master = driver.
interface issue_scoreboard_if #(
  parameter int STALL_CNT_W = 16
);
  import rv_issue_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            instr_word;
  logic                   issue_valid;
  logic                   issue_ready;
  reg_idx_t               rs1;
  reg_idx_t               rs2;
  reg_idx_t               rd;
  logic                   wb_valid;
  reg_idx_t               wb_rd;
  logic                   flush;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport slave (
    input  in_valid, instr_word, issue_ready,
    input  wb_valid, wb_rd, flush,
    output in_ready, issue_valid,
    output rs1, rs2, rd, stall_cnt
  );

  modport master (
    output in_valid, instr_word, issue_ready,
    output wb_valid, wb_rd, flush,
    input  in_ready, issue_valid,
    input  rs1, rs2, rd, stall_cnt
  );

endinterface

// File: rtl/issue_scoreboard_regs.sv
// Busy vector (one bit per register, x0 never busy). Ports: set_en/set_idx
// mark, clr_en/clr_idx retire, flush wipes all; set wins over clear.
module scoreboard_regs
  import rv_issue_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_en,
  input  reg_idx_t           set_idx,
  input  logic               clr_en,
  input  reg_idx_t           clr_idx,
  input  logic               flush,
  output logic [REG_NUM-1:0] busy
);

  logic [REG_NUM-1:0] busy_d;
  logic [REG_NUM-1:0] busy_q;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (clr_en) busy_d[clr_idx] = 1'b0;
      // set after clear: a same-cycle issue to R keeps R busy
      if (set_en) busy_d[set_idx] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue stage with RAW/WAW scoreboard and a 1-entry output register.
// Ports: clk, rst_n, bus (slave). Option: SCOREBOARD_BYPASS_EN.
module issue_scoreboard
  import rv_issue_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  issue_scoreboard_if.slave bus
);

  ops_t                   f_ops;
  logic [REG_NUM-1:0]     busy;
  logic [REG_NUM-1:0]     hzd_busy;
  logic                   hazard;
  logic                   out_free;
  logic                   in_ready;
  logic                   accept;
  logic                   issue_valid;

  iss_state_e             state_d, state_q;
  ops_t                   ops_d, ops_q;
  logic [STALL_CNT_W-1:0] stall_d, stall_q;

  logic                   unused_word;

  assign f_ops.rs1 = bus.instr_word[RS1_LSB +: REG_W];
  assign f_ops.rs2 = bus.instr_word[RS2_LSB +: REG_W];
  assign f_ops.rd  = bus.instr_word[RD_LSB  +: REG_W];

  assign unused_word = ^{bus.instr_word[31:25],
                         bus.instr_word[14:12],
                         bus.instr_word[6:0]};

`ifdef SCOREBOARD_BYPASS_EN
  // a register retiring this cycle no longer blocks issue
  always_comb begin
    hzd_busy = busy;
    if (bus.wb_valid) hzd_busy[bus.wb_rd] = 1'b0;
  end
`else
  assign hzd_busy = busy;
`endif

  assign hazard = hzd_busy[f_ops.rs1]
                | hzd_busy[f_ops.rs2]
                | hzd_busy[f_ops.rd];

  assign issue_valid = (state_q == ST_FULL);
  assign out_free    = !issue_valid || bus.issue_ready;
  assign in_ready    = out_free && !hazard && !bus.flush;
  assign accept      = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (bus.flush)
      state_d = ST_EMPTY;
    else if (accept)
      state_d = ST_FULL;
    else if (issue_valid && !bus.issue_ready)
      state_d = ST_FULL;
    else if (bus.in_valid && hazard)
      state_d = ST_STALL;
    else
      state_d = ST_EMPTY;
  end

  always_comb begin
    ops_d = ops_q;
    if (accept) ops_d = f_ops;
  end

  always_comb begin
    stall_d = stall_q;
    if (bus.in_valid && hazard && !bus.flush &&
        (stall_q != '1))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      stall_q <= stall_d;
    end
  end

  scoreboard_regs u_regs (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (accept && (f_ops.rd != '0)),
    .set_idx (f_ops.rd),
    .clr_en  (bus.wb_valid),
    .clr_idx (bus.wb_rd),
    .flush   (bus.flush),
    .busy    (busy)
  );

  assign bus.in_ready    = in_ready;
  assign bus.issue_valid = issue_valid;
  assign bus.rs1         = ops_q.rs1;
  assign bus.rs2         = ops_q.rs2;
  assign bus.rd          = ops_q.rd;
  assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench for issue_scoreboard: directed scenarios then random
// traffic, checked against a register-level reference model.
module tb_issue_scoreboard;
  import rv_issue_pkg::*;

  localparam int W = 4;
  localparam int SMAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  issue_scoreboard_if #(.STALL_CNT_W(W)) bus ();

  issue_scoreboard #(.STALL_CNT_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int rs1;
    int rs2;
    int rd;
  } exp_t;

  exp_t expq[$];

  bit [31:0] mbusy;
  bit        mvalid;
  int        mstall;

  function automatic void chk(string name,
                              logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mk(int rd, int r1, int r2);
    logic [31:0] w;
    w = 32'h33;
    w[11:7]  = rd[4:0];
    w[19:15] = r1[4:0];
    w[24:20] = r2[4:0];
    return w;
  endfunction

  // reference model: evaluated mid-cycle on the stable inputs
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      mbusy  = '0;
      mvalid = 1'b0;
      mstall = 0;
      expq.delete();
    end else begin
      bit [31:0] eff;
      bit haz, erdy, acc;
      int r1, r2, rd;
      r1 = int'(bus.instr_word[19:15]);
      r2 = int'(bus.instr_word[24:20]);
      rd = int'(bus.instr_word[11:7]);
      eff = mbusy;
`ifdef SCOREBOARD_BYPASS_EN
      if (bus.wb_valid) eff[bus.wb_rd] = 1'b0;
`endif
      haz  = eff[r1] | eff[r2] | eff[rd];
      erdy = (!mvalid || bus.issue_ready) && !haz && !bus.flush;
      chk("in_ready", {31'b0, bus.in_ready}, {31'b0, erdy});
      chk("issue_valid", {31'b0, bus.issue_valid}, {31'b0, mvalid});
      chk("stall_cnt", 32'(bus.stall_cnt), 32'(mstall));
      acc = bus.in_valid && erdy;
      if (bus.in_valid && haz && !bus.flush && mstall < SMAX)
        mstall++;
      if (bus.flush) begin
        mbusy  = '0;
        mvalid = 1'b0;
        expq.delete();
      end else begin
        if (mvalid && bus.issue_ready) mvalid = 1'b0;
        if (acc) begin
          mvalid = 1'b1;
          expq.push_back('{rs1: r1, rs2: r2, rd: rd});
        end
        if (bus.wb_valid) mbusy[bus.wb_rd] = 1'b0;
        if (acc) mbusy[rd] = 1'b1;
        mbusy[0] = 1'b0;
      end
    end
  end

  // monitor: compare presented operands with the oldest expected issue
  always begin
    @(negedge clk);
    if (rst_n && bus.issue_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_unexpected: got rd=%0d expected none",
                 bus.rd);
      end else begin
        chk("rs1", 32'(bus.rs1), 32'(expq[0].rs1));
        chk("rs2", 32'(bus.rs2), 32'(expq[0].rs2));
        chk("rd",  32'(bus.rd),  32'(expq[0].rd));
        if (bus.issue_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic drive(input logic iv, input logic [31:0] w,
                       input logic ir, input logic wv,
                       input logic [4:0] wr, input logic fl,
                       output bit acc);
    bus.in_valid    = iv;
    bus.instr_word  = w;
    bus.issue_ready = ir;
    bus.wb_valid    = wv;
    bus.wb_rd       = wr;
    bus.flush       = fl;
    @(negedge clk);
    acc = iv && bus.in_ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    logic [31:0] w;
    bus.in_valid    = 1'b0;
    bus.instr_word  = '0;
    bus.issue_ready = 1'b0;
    bus.wb_valid    = 1'b0;
    bus.wb_rd       = '0;
    bus.flush       = 1'b0;
    #1;
    chk("rst_issue_valid", {31'b0, bus.issue_valid}, 32'd0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // add x3,x1,x2
    drive(1, 32'h002081B3, 1, 0, 0, 0, acc);
    chk("first_accept", {31'b0, acc}, 32'd1);
    // add x5,x3,x4 blocked by x3
    repeat (3) begin
      drive(1, 32'h004182B3, 1, 0, 0, 0, acc);
      chk("raw_stall", {31'b0, acc}, 32'd0);
    end
    drive(1, 32'h004182B3, 1, 1, 3, 0, acc);
`ifdef SCOREBOARD_BYPASS_EN
    chk("wb_cycle_accept", {31'b0, acc}, 32'd1);
`else
    chk("wb_cycle_accept", {31'b0, acc}, 32'd0);
    drive(1, 32'h004182B3, 1, 0, 0, 0, acc);
    chk("after_wb_accept", {31'b0, acc}, 32'd1);
`endif

    // downstream back-pressure: operands must hold
    repeat (3) begin
      drive(1, mk(6, 1, 2), 0, 0, 0, 0, acc);
      chk("hold_no_accept", {31'b0, acc}, 32'd0);
    end
    drive(1, mk(6, 1, 2), 1, 0, 0, 0, acc);
    chk("release_accept", {31'b0, acc}, 32'd1);

    // rd = x0 never becomes busy
    drive(1, mk(0, 1, 2), 1, 0, 0, 0, acc);
    chk("rd0_accept", {31'b0, acc}, 32'd1);
    drive(1, mk(8, 0, 0), 1, 1, 0, 0, acc);
    chk("x0_no_hazard", {31'b0, acc}, 32'd1);

    // set beats same-cycle clear, then flush wipes everything
    drive(1, mk(7, 1, 2), 1, 1, 7, 0, acc);
    chk("rd7_accept", {31'b0, acc}, 32'd1);
    drive(1, mk(9, 7, 1), 1, 0, 0, 0, acc);
    chk("rd7_still_busy", {31'b0, acc}, 32'd0);
    drive(1, mk(9, 7, 1), 1, 0, 0, 1, acc);
    chk("flush_ignores_in", {31'b0, acc}, 32'd0);
    drive(1, mk(9, 7, 5), 1, 0, 0, 0, acc);
    chk("post_flush_accept", {31'b0, acc}, 32'd1);

    // asynchronous reset while the output holds an instruction
    drive(1, mk(10, 1, 2), 1, 0, 0, 0, acc);
    drive(1, mk(10, 10, 1), 0, 0, 0, 0, acc);
    chk("pre_rst_full", {31'b0, bus.issue_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, bus.issue_valid}, 32'd0);
    chk("async_rst_rd", 32'(bus.rd), 32'd0);
    chk("async_rst_stall", 32'(bus.stall_cnt), 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // random traffic over a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      w = $urandom;
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      drive(logic'($urandom_range(0, 9) < 7), w,
            logic'($urandom_range(0, 9) < 7),
            logic'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)),
            logic'($urandom_range(0, 99) < 3), acc);
    end

    drive(0, '0, 1, 0, 0, 1, acc);
    drive(0, '0, 1, 0, 0, 0, acc);
    chk("final_queue_empty", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
